// File: rtl/xor_parity_accum.sv
// xor_parity_accum: streaming XOR fold of a packet of WIDTH-bit words.
// Each packet produces a bitwise fold, an even/odd parity bit, a saturating
// word count and an overflow flag, held in a single result buffer until the
// consumer takes it.
//
// Handshake: a beat transfers on a rising clk edge where valid & ready are
// both 1; the source holds data stable while valid is high and ready is low,
// and ready never depends combinationally on valid.
module xor_parity_accum #(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 16,
    parameter int CW        = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             odd_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_fold,
    output logic             out_parity,
    output logic [CW-1:0]    out_count,
    output logic             out_overflow
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             accept, handshake;
    logic [WIDTH-1:0] acc_q, fold_next;
    logic [CW-1:0]    cnt_q, cnt_next;
    logic             ovf_q, ovf_next;
    logic             mode_q, mode_eff;

    // The result buffer is occupied exactly while in HOLD, so input is
    // refused for the whole hold including the handshake cycle.
    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid & in_ready;
    assign handshake = out_valid & out_ready;

    // Accumulator values after folding in the beat currently presented.
    always_comb begin
        fold_next = acc_q ^ in_data;
        cnt_next  = cnt_q;
        ovf_next  = ovf_q;
        mode_eff  = mode_q;
        if (state_q == IDLE) begin
            fold_next = in_data;
            cnt_next  = CW'(1);
            ovf_next  = 1'b0;
            mode_eff  = odd_mode;
        end else if (cnt_q == MAX_CNT) begin
            ovf_next  = 1'b1;
        end else begin
            cnt_next  = cnt_q + CW'(1);
        end
    end

    // Next-state logic: open a packet, close it on the last beat, drain on handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = in_last ? HOLD : ACCUM;
            end
            ACCUM: begin
                if (accept && in_last) state_d = HOLD;
            end
            HOLD: begin
                if (handshake) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Accumulator, mode latch and registered result; results persist after
    // the handshake and are cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            mode_q       <= 1'b0;
            out_fold     <= '0;
            out_parity   <= 1'b0;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else if (accept) begin
            acc_q  <= fold_next;
            cnt_q  <= cnt_next;
            ovf_q  <= ovf_next;
            mode_q <= mode_eff;
            if (in_last) begin
                out_fold     <= fold_next;
                out_parity   <= (^fold_next) ^ mode_eff;
                out_count    <= cnt_next;
                out_overflow <= ovf_next;
            end
        end else if (handshake) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xor_parity_accum.sv
// Directed bench for xor_parity_accum with WIDTH=8, MAX_WORDS=4.
module tb_xor_parity_accum;

    localparam int WIDTH     = 8;
    localparam int MAX_WORDS = 4;
    localparam int CW        = $clog2(MAX_WORDS + 1);

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             odd_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_fold;
    logic             out_parity;
    logic [CW-1:0]    out_count;
    logic             out_overflow;

    int checks = 0;
    int errors = 0;

    xor_parity_accum #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .odd_mode(odd_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_fold(out_fold), .out_parity(out_parity),
        .out_count(out_count), .out_overflow(out_overflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded wait).
    task automatic send_beat(input logic [7:0] d, input logic last, input logic mode);
        bit done;
        done     = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        odd_mode = mode;
        for (int i = 0; i < 50 && !done; i++) begin
            if (in_ready) done = 1;
            tick();
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [7:0] f, input logic p,
                                input logic [CW-1:0] c, input logic o);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_fold"}, {24'd0, out_fold}, {24'd0, f});
        check({tag, "_parity"}, {31'd0, out_parity}, {31'd0, p});
        check({tag, "_count"}, {29'd0, out_count}, {29'd0, c});
        check({tag, "_ovf"}, {31'd0, out_overflow}, {31'd0, o});
    endtask

    // Complete the output handshake and confirm the buffer frees up.
    task automatic take_result(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_ready_after"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        odd_mode  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst0_valid", {31'd0, out_valid}, 32'd0);
        check("rst0_fold", {24'd0, out_fold}, 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst0_ready", {31'd0, in_ready}, 32'd1);

        // Reset while a result is pending: outputs clear immediately.
        send_beat(8'h5A, 1'b1, 1'b1);
        check("pend_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b1;
        in_data  = 8'h33;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_fold", {24'd0, out_fold}, 32'd0);
        check("arst_parity", {31'd0, out_parity}, 32'd0);
        check("arst_count", {29'd0, out_count}, 32'd0);
        check("arst_ovf", {31'd0, out_overflow}, 32'd0);
        repeat (3) tick();
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        check("arst_ready", {31'd0, in_ready}, 32'd1);
        check("arst_noresult", {31'd0, out_valid}, 32'd0);

        // Single word, even then odd parity.
        send_beat(8'hA5, 1'b1, 1'b0);
        check_result("a5_even", 8'hA5, 1'b0, 3'd1, 1'b0);
        take_result("a5_even");
        send_beat(8'hA5, 1'b1, 1'b1);
        check_result("a5_odd", 8'hA5, 1'b1, 3'd1, 1'b0);
        take_result("a5_odd");

        // Three words with consumer stalled for 5 cycles.
        send_beat(8'h0F, 1'b0, 1'b0);
        send_beat(8'hF0, 1'b0, 1'b0);
        send_beat(8'h3C, 1'b1, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h77;
        for (int i = 0; i < 5; i++) begin
            check_result("stall", 8'hC3, 1'b0, 3'd3, 1'b0);
            check("stall_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        in_valid = 1'b0;
        take_result("stall");

        // Six words of 0x01: count saturates at 4, overflow set.
        for (int i = 0; i < 6; i++) send_beat(8'h01, (i == 5), 1'b0);
        check_result("ovf6", 8'h00, 1'b0, 3'd4, 1'b1);
        take_result("ovf6");
        send_beat(8'h01, 1'b1, 1'b0);
        check_result("after_ovf", 8'h01, 1'b1, 3'd1, 1'b0);
        take_result("after_ovf");

        // Back-to-back packets, in_valid held, consumer always ready.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        in_last   = 1'b1;
        odd_mode  = 1'b0;
        check("b2b_ready0", {31'd0, in_ready}, 32'd1);
        tick();
        in_data = 8'h01;
        check_result("b2b_first", 8'hFF, 1'b0, 3'd1, 1'b0);
        check("b2b_hold_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check("b2b_hs_valid", {31'd0, out_valid}, 32'd0);
        check("b2b_bubble_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_result("b2b_second", 8'h01, 1'b1, 3'd1, 1'b0);
        tick();
        out_ready = 1'b0;
        check("b2b_done", {31'd0, out_valid}, 32'd0);

        // odd_mode changes mid-packet are ignored.
        send_beat(8'h01, 1'b0, 1'b1);
        send_beat(8'h02, 1'b0, 1'b0);
        send_beat(8'h04, 1'b1, 1'b0);
        check_result("mode_latch", 8'h07, 1'b0, 3'd3, 1'b0);
        take_result("mode_latch");

        // Reset mid-packet discards the partial packet.
        send_beat(8'h11, 1'b0, 1'b1);
        send_beat(8'h22, 1'b0, 1'b1);
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("midrst_noresult", {31'd0, out_valid}, 32'd0);
            tick();
        end
        send_beat(8'h80, 1'b1, 1'b0);
        check_result("post_rst", 8'h80, 1'b1, 3'd1, 1'b0);
        take_result("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xor_parity_accum.md
Name: xor_parity_accum

Overview:
- Streaming, parametrised successor to the team's 2-input CMOS XOR cell.
- XOR-reduces a packet of WIDTH-bit words arriving over a valid/ready stream.
- Produces a bitwise fold, a 1-bit even/odd parity, a word count and an overflow flag per packet.
- Sits between a packet source and a checker/ECC stage that needs per-packet parity.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- MAX_WORDS, 16, count saturation limit; more words in one packet sets overflow (>=1).
- CW, $clog2(MAX_WORDS+1), derived width of count output; not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept a word
- in_data  input  WIDTH  input word
- in_last  input  1  final word of packet, qualified by in_valid
- odd_mode  input  1  0 = even parity, 1 = odd parity; sampled on first accepted beat of a packet
- out_valid  output  1  packet result valid
- out_ready  input  1  consumer accepts result
- out_fold  output  WIDTH  XOR of all accepted words in packet
- out_parity  output  1  reduction XOR of out_fold, XOR'd with the latched odd_mode
- out_count  output  CW  number of words in packet, saturating at MAX_WORDS
- out_overflow  output  1  packet contained more than MAX_WORDS words

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE; accumulator, count, overflow and mode latch = 0.
  - out_valid=0, out_fold=0, out_parity=0, out_count=0, out_overflow=0.
  - in_ready=1 from the first cycle after rst_n rises.
- Accept = in_valid & in_ready. Output handshake = out_valid & out_ready.
- States:
  - IDLE: no packet open; in_ready=1.
    - Accept with in_last=0 -> ACCUM. Sets acc=in_data, cnt=1, latches odd_mode.
    - Accept with in_last=1 -> HOLD. Result is formed directly from this word.
  - ACCUM: in_ready=1.
    - Each accept: acc ^= in_data; cnt=min(cnt+1, MAX_WORDS).
    - If cnt==MAX_WORDS before the increment, ovf=1 (sticky for the packet).
    - Accept with in_last=1 -> HOLD.
  - HOLD: in_ready=0; out_valid=1.
    - Outputs are registered and stable until the output handshake.
    - On handshake -> IDLE; acc, cnt, ovf cleared.
- Latency: out_valid rises on the clock edge that accepts the last beat, i.e. visible the cycle after the in_last beat.
  - out_fold = acc ^ last data.
  - out_count includes the last word.
  - out_parity = ^out_fold ^ mode latch.
- Single result buffer:
  - No input accepted while out_valid=1, including the handshake cycle.
  - Earliest next accept is the cycle after the handshake, so there is one bubble per packet.
- Back-pressure: in_valid without accept is ignored; source holds the word.
- odd_mode changes mid-packet have no effect; only the first-beat sample is used.
- MAX_WORDS=1: a 2nd word in a packet sets overflow; count stays 1.
- Overflowed packets: the fold still covers every accepted word; only the count saturates.
- Reset mid-packet or in HOLD: the partial packet or pending result is discarded and no result is emitted. The next packet starts clean.
- out_* are don't-care-free: held at their last value with out_valid=0 after handshake; fold/count are cleared only by reset.

Test Plan (WIDTH=8, MAX_WORDS=4):
- Reset: rst_n low for 3 cycles mid-traffic -> out_valid=0, all outputs 0 immediately; in_ready=1 the cycle after release.
- Single word 0xA5 with in_last=1:
  - odd_mode=0 -> next cycle out_fold=0xA5, parity=0, count=1, overflow=0.
  - Repeat with odd_mode=1 -> parity=1.
- Words 0x0F, 0xF0, 0x3C (last) with out_ready=0 for 5 cycles:
  - fold=0xC3, parity=0, count=3.
  - Outputs stable and in_ready=0 throughout; handshake on out_ready=1, in_ready=1 the next cycle.
- Six words of 0x01, last on the 6th -> fold=0x00, parity=0, count=4, overflow=1. The next packet 0x01 (last) -> overflow=0, count=1.
- Back-to-back with out_ready=1:
  - Packet 0xFF (last) then 0x01 (last), in_valid held high -> two results, fold 0xFF (parity 0) and 0x01 (parity 1).
  - 0x01 accepted exactly the cycle after the first handshake.
  - odd_mode toggled during the 2nd beat of a 3-word packet -> parity uses the first-beat value.
- Reset mid-packet: after 0x11, 0x22 accepted, pulse rst_n -> no result emitted. Then 0x80 (last), even mode -> fold=0x80, parity=1, count=1.
